// File: rtl/pipeline_sched_if.sv
// Hazard-request inputs and stall/flush control outputs for the pipeline scheduler.
// The slave modport is the scheduler; the master modport is the pipeline side.
interface pipeline_sched_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       IF_ID_RSaddr_i;
   logic [4:0]       IF_ID_RTaddr_i;
   logic [4:0]       ID_EX_RTaddr_i;
   logic             ID_EX_MemRead_i;
   logic             ID_muldiv_i;
   logic             EX_branch_taken_i;
   logic             MEM_dmem_wait_i;
   logic             PC_stall_o;
   logic             IF_ID_stall_o;
   logic             ID_EX_bubble_o;
   logic             EX_MEM_stall_o;
   logic             IF_ID_flush_o;
   logic             ID_EX_flush_o;
   logic             muldiv_start_o;
   logic             muldiv_busy_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_RTaddr_i, ID_EX_MemRead_i,
             ID_muldiv_i, EX_branch_taken_i, MEM_dmem_wait_i,
      input  PC_stall_o, IF_ID_stall_o, ID_EX_bubble_o, EX_MEM_stall_o,
             IF_ID_flush_o, ID_EX_flush_o, muldiv_start_o, muldiv_busy_o,
             state_o, stall_cnt_o
   );

   modport slave (
      input  IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_RTaddr_i, ID_EX_MemRead_i,
             ID_muldiv_i, EX_branch_taken_i, MEM_dmem_wait_i,
      output PC_stall_o, IF_ID_stall_o, ID_EX_bubble_o, EX_MEM_stall_o,
             IF_ID_flush_o, ID_EX_flush_o, muldiv_start_o, muldiv_busy_o,
             state_o, stall_cnt_o
   );
endinterface

// File: rtl/pipeline_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline: load-use, taken branch,
// multi-cycle mul/div occupancy and data-memory wait, plus a saturating stall counter.
module pipeline_sched #(
   parameter int MULDIV_LAT = 4,   // 2..15
   parameter int CNT_W      = 16   // must match the interface CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   pipeline_sched_if.slave  bus
);
   typedef enum logic [1:0] {
      RUN    = 2'b00,
      MULDIV = 2'b01,
      FLUSH  = 2'b10
   } state_t;

   state_t           r_state;
   logic [3:0]       r_mdcnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_lu;
   logic w_pc_stall;
   logic w_ifid_stall;
   logic w_bubble;
   logic w_exmem_stall;
   logic w_ifid_flush;
   logic w_idex_flush;
   logic w_start;

   // Register $0 is hardwired zero, so a load targeting it never hazards.
   assign w_lu = bus.ID_EX_MemRead_i && (bus.ID_EX_RTaddr_i != 5'd0) &&
                 ((bus.ID_EX_RTaddr_i == bus.IF_ID_RSaddr_i) ||
                  (bus.ID_EX_RTaddr_i == bus.IF_ID_RTaddr_i));

   always_comb begin
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_bubble      = 1'b0;
      w_exmem_stall = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      w_start       = 1'b0;
      if (bus.MEM_dmem_wait_i) begin
         w_pc_stall    = 1'b1;
         w_ifid_stall  = 1'b1;
         w_exmem_stall = 1'b1;
      end else if (bus.EX_branch_taken_i) begin
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (r_state == MULDIV || (r_state == RUN && w_lu)) begin
         w_pc_stall   = 1'b1;
         w_ifid_stall = 1'b1;
         w_bubble     = 1'b1;
      end else if (r_state == RUN && bus.ID_muldiv_i) begin
         w_start = 1'b1;
      end
   end

   // The mul/div window keeps counting through memory waits and taken branches.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= RUN;
         r_mdcnt     <= 4'd0;
         r_stall_cnt <= '0;
      end else begin
         if (w_pc_stall && r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         case (r_state)
            RUN: begin
               if (!bus.MEM_dmem_wait_i && bus.EX_branch_taken_i) begin
                  r_state <= FLUSH;
               end else if (w_start) begin
                  r_state <= MULDIV;
                  r_mdcnt <= 4'(MULDIV_LAT - 1);
               end
            end
            MULDIV: begin
               r_mdcnt <= r_mdcnt - 4'd1;
               if (r_mdcnt <= 4'd1)
                  r_state <= RUN;
            end
            FLUSH: begin
               if (!bus.MEM_dmem_wait_i)
                  r_state <= bus.EX_branch_taken_i ? FLUSH : RUN;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign bus.PC_stall_o     = w_pc_stall;
   assign bus.IF_ID_stall_o  = w_ifid_stall;
   assign bus.ID_EX_bubble_o = w_bubble;
   assign bus.EX_MEM_stall_o = w_exmem_stall;
   assign bus.IF_ID_flush_o  = w_ifid_flush;
   assign bus.ID_EX_flush_o  = w_idex_flush;
   assign bus.muldiv_start_o = w_start;
   assign bus.muldiv_busy_o  = (r_state == MULDIV);
   assign bus.state_o        = r_state;
   assign bus.stall_cnt_o    = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_sched.sv
// Table-driven, scoreboarded bench for pipeline_sched plus hand sequences for
// asynchronous reset and counter saturation (CNT_W=4 instance).
`timescale 1ns/1ps
module tb_pipeline_sched;
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipeline_sched_if #(.CNT_W(16)) bus ();
   pipeline_sched_if #(.CNT_W(4))  sbus ();

   pipeline_sched #(.MULDIV_LAT(4), .CNT_W(16)) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   pipeline_sched #(.MULDIV_LAT(4), .CNT_W(4)) u_sat (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (sbus)
   );

   typedef struct {
      string      name;
      logic [4:0] rs, rt, exrt;
      logic       mr, md, br, wt;
      logic [7:0] ctl;
      logic [1:0] st;
      logic [15:0] cnt;
   } vec_t;

   typedef struct {
      string       name;
      logic [7:0]  ctl;
      logic [1:0]  st;
      logic [15:0] cnt;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // ctl = {pc_stall, ifid_stall, bubble, exmem_stall, ifid_flush, idex_flush, start, busy}
   logic [7:0] w_ctl;
   assign w_ctl = {bus.PC_stall_o, bus.IF_ID_stall_o, bus.ID_EX_bubble_o, bus.EX_MEM_stall_o,
                   bus.IF_ID_flush_o, bus.ID_EX_flush_o, bus.muldiv_start_o, bus.muldiv_busy_o};

   function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] exrt, input logic mr, input logic md,
                               input logic br, input logic wt, input logic [7:0] ctl,
                               input logic [1:0] st, input logic [15:0] cnt);
      vec_t v;
      v.name = n; v.rs = rs; v.rt = rt; v.exrt = exrt;
      v.mr = mr; v.md = md; v.br = br; v.wt = wt;
      v.ctl = ctl; v.st = st; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.IF_ID_RSaddr_i    = v.rs;
      bus.IF_ID_RTaddr_i    = v.rt;
      bus.ID_EX_RTaddr_i    = v.exrt;
      bus.ID_EX_MemRead_i   = v.mr;
      bus.ID_muldiv_i       = v.md;
      bus.EX_branch_taken_i = v.br;
      bus.MEM_dmem_wait_i   = v.wt;
   endtask

   task automatic check_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk({e.name, "_ctl"},   {24'd0, w_ctl},       {24'd0, e.ctl});
      chk({e.name, "_state"}, {30'd0, bus.state_o}, {30'd0, e.st});
      chk({e.name, "_cnt"},   {16'd0, bus.stall_cnt_o}, {16'd0, e.cnt});
      $display("vec %-12s ctl=%02h state=%0d cnt=%0d", e.name, w_ctl, bus.state_o, bus.stall_cnt_o);
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      drive(v);
      e.name = v.name; e.ctl = v.ctl; e.st = v.st; e.cnt = v.cnt;
      exp_q.push_back(e);
      @(negedge clk);
      check_out();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t z;
      //            name          rs    rt    exrt  mr md br wt   ctl     st     cnt
      tbl.push_back(mk("idle",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 2'd0, 16'd0));
      tbl.push_back(mk("lu_rs",      5'd8, 5'd0, 5'd8, 1, 0, 0, 0, 8'hE0, 2'd0, 16'd0));
      tbl.push_back(mk("lu_r0",      5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 8'h00, 2'd0, 16'd1));
      tbl.push_back(mk("lu_rt",      5'd3, 5'd5, 5'd5, 1, 0, 0, 0, 8'hE0, 2'd0, 16'd1));
      tbl.push_back(mk("no_match",   5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 8'h00, 2'd0, 16'd2));
      tbl.push_back(mk("no_memrd",   5'd7, 5'd0, 5'd7, 0, 0, 0, 0, 8'h00, 2'd0, 16'd2));
      tbl.push_back(mk("lu_vs_md",   5'd9, 5'd0, 5'd9, 1, 1, 0, 0, 8'hE0, 2'd0, 16'd2));
      tbl.push_back(mk("md_start",   5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 8'h02, 2'd0, 16'd3));
      tbl.push_back(mk("md_1",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'hE1, 2'd1, 16'd3));
      tbl.push_back(mk("md_2",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'hE1, 2'd1, 16'd4));
      tbl.push_back(mk("md_3",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'hE1, 2'd1, 16'd5));
      tbl.push_back(mk("md_done",    5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 2'd0, 16'd6));
      tbl.push_back(mk("br_lu",      5'd4, 5'd0, 5'd4, 1, 1, 1, 0, 8'h0C, 2'd0, 16'd6));
      tbl.push_back(mk("flush_sup",  5'd4, 5'd0, 5'd4, 1, 1, 0, 0, 8'h00, 2'd2, 16'd6));
      tbl.push_back(mk("post_flush", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 2'd0, 16'd6));
      tbl.push_back(mk("wait_run",   5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 8'hD0, 2'd0, 16'd6));
      tbl.push_back(mk("wait_br",    5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 8'hD0, 2'd0, 16'd7));
      tbl.push_back(mk("md_start2",  5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 8'h02, 2'd0, 16'd8));
      tbl.push_back(mk("md_a",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'hE1, 2'd1, 16'd8));
      tbl.push_back(mk("md_wait1",   5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 8'hD1, 2'd1, 16'd9));
      tbl.push_back(mk("md_wait2",   5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 8'hD1, 2'd1, 16'd10));
      tbl.push_back(mk("after_wait", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 2'd0, 16'd11));
      tbl.push_back(mk("md_start3",  5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 8'h02, 2'd0, 16'd11));
      tbl.push_back(mk("md_br",      5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'h0D, 2'd1, 16'd11));
      tbl.push_back(mk("md_b",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'hE1, 2'd1, 16'd11));
      tbl.push_back(mk("md_c",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'hE1, 2'd1, 16'd12));
      tbl.push_back(mk("flush_in",   5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'h0C, 2'd0, 16'd13));
      tbl.push_back(mk("flush_hold", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 8'hD0, 2'd2, 16'd13));
      tbl.push_back(mk("flush_rebr", 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'h0C, 2'd2, 16'd14));
      tbl.push_back(mk("flush_end",  5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 8'h00, 2'd2, 16'd14));
      tbl.push_back(mk("idle2",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 2'd0, 16'd14));

      z = mk("zero", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00, 2'd0, 16'd0);
      rst_n = 1'b0;
      drive(z);
      sbus.IF_ID_RSaddr_i    = 5'd0;
      sbus.IF_ID_RTaddr_i    = 5'd0;
      sbus.ID_EX_RTaddr_i    = 5'd0;
      sbus.ID_EX_MemRead_i   = 1'b0;
      sbus.ID_muldiv_i       = 1'b0;
      sbus.EX_branch_taken_i = 1'b0;
      sbus.MEM_dmem_wait_i   = 1'b0;

      // Reset: controls are combinational, so mem-wait still shows through.
      #2;
      chk("rst_ctl",   {24'd0, w_ctl}, 32'h00);
      chk("rst_state", {30'd0, bus.state_o}, 32'd0);
      chk("rst_cnt",   {16'd0, bus.stall_cnt_o}, 32'd0);
      bus.MEM_dmem_wait_i = 1'b1;
      #1;
      chk("rst_wait_ctl", {24'd0, w_ctl}, 32'hD0);
      bus.MEM_dmem_wait_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_hold_cnt", {16'd0, bus.stall_cnt_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_ctl",   {24'd0, w_ctl}, 32'h00);
      chk("rel_state", {30'd0, bus.state_o}, 32'd0);
      $display("reset sequence ctl=%02h state=%0d cnt=%0d", w_ctl, bus.state_o, bus.stall_cnt_o);

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // Asynchronous reset in the middle of a mul/div window.
      @(posedge clk); #1; z.md = 1'b1; drive(z);
      @(posedge clk); #1; z.md = 1'b0; drive(z);
      #2;
      chk("mdrst_pre_state", {30'd0, bus.state_o}, 32'd1);
      chk("mdrst_pre_stall", {31'd0, bus.PC_stall_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mdrst_state", {30'd0, bus.state_o}, 32'd0);
      chk("mdrst_busy",  {31'd0, bus.muldiv_busy_o}, 32'd0);
      chk("mdrst_stall", {31'd0, bus.PC_stall_o}, 32'd0);
      chk("mdrst_cnt",   {16'd0, bus.stall_cnt_o}, 32'd0);
      $display("mid-muldiv reset state=%0d busy=%0d", bus.state_o, bus.muldiv_busy_o);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mdrst_after_state", {30'd0, bus.state_o}, 32'd0);
      chk("mdrst_after_stall", {31'd0, bus.PC_stall_o}, 32'd0);

      // Saturation of the 4-bit stall counter: 21 stalled edges end at 15.
      @(posedge clk); #1;
      sbus.MEM_dmem_wait_i = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      chk("sat_pc_stall", {31'd0, sbus.PC_stall_o}, 32'd1);
      chk("sat_cnt14", {28'd0, sbus.stall_cnt_o}, 32'd14);
      repeat (7) @(posedge clk);
      #1;
      chk("sat_cnt15", {28'd0, sbus.stall_cnt_o}, 32'd15);
      $display("saturation cnt=%0d", sbus.stall_cnt_o);
      sbus.MEM_dmem_wait_i = 1'b0;
      @(posedge clk); #1;
      chk("sat_hold", {28'd0, sbus.stall_cnt_o}, 32'd15);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
